// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: groups the control-unit handshake and the instruction
// memory read port of the fetch stage into one bundle.
//   slave  : the fetch unit (drives memory request and instruction outputs)
//   master : the environment (control unit + instruction memory)
interface instr_fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) ();
    logic               PC_INCR;
    logic               INSTR_DONE;
    logic               IMEM_EN;
    logic [PC_W-1:0]    IMEM_ADDR;
    logic [INSTR_W-1:0] IMEM_DATA;
    logic [INSTR_W-1:0] INSTR;
    logic               STAGE_VALID;
    logic [PC_W-1:0]    PC;
    logic               FETCH_ERR;

    modport slave (
        input  PC_INCR, INSTR_DONE, IMEM_DATA,
        output IMEM_EN, IMEM_ADDR, INSTR, STAGE_VALID, PC, FETCH_ERR
    );

    modport master (
        output PC_INCR, INSTR_DONE, IMEM_DATA,
        input  IMEM_EN, IMEM_ADDR, INSTR, STAGE_VALID, PC, FETCH_ERR
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the SIMD control unit. Reads words from
// a synchronous instruction memory (1-cycle latency) into a one-entry staging
// buffer and presents the committed word on INSTR.
// A read is "in flight" from the cycle IMEM_EN is high until the cycle its data
// is captured (imem_en_q or cap_q set).
// Optional feature macro: IFU_HALT_ON_STOP_EN -- committing a STOP word
// (INSTR[2:0]==3'd6) parks the unit in HALT until reset.
module instr_fetch_unit #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    instr_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] stage_q, stage_d;
    logic               stage_valid_q, stage_valid_d;
    logic               imem_en_q, imem_en_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               cap_q, cap_d;
    logic               pend_q, pend_d;
    logic               fetch_err_q, fetch_err_d;

    logic               in_flight_s;
    logic               done_s;
    logic               take_direct_s;
    logic               take_stage_s;
    logic               fetch_s;

    // HALT ignores commits entirely; elsewhere INSTR_DONE is acted on.
    assign done_s        = bus.INSTR_DONE & (state_q != ST_HALT);
    assign in_flight_s   = imem_en_q | cap_q;
    // Capture cycle with a commit waiting: memory data goes straight to INSTR.
    assign take_direct_s = cap_q & (pend_q | (done_s & ~stage_valid_q));
    // Ordinary commit of the staged word.
    assign take_stage_s  = ~cap_q & done_s & stage_valid_q;

`ifdef IFU_HALT_ON_STOP_EN
    localparam logic [2:0] STOP_OPC = 3'd6;
    logic stop_commit_s;

    assign stop_commit_s = (take_direct_s & (bus.IMEM_DATA[2:0] == STOP_OPC)) |
                           (take_stage_s  & (stage_q[2:0]       == STOP_OPC));
`endif

    // Next-state logic: commit/capture path, fetch acceptance, FSM transitions.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        stage_d       = stage_q;
        stage_valid_d = stage_valid_q;
        imem_en_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        cap_d         = imem_en_q;
        pend_d        = pend_q;
        fetch_err_d   = fetch_err_q;
        fetch_s       = 1'b0;

        // Commit and capture: at most one of these paths applies per cycle.
        if (take_direct_s) begin
            instr_d = bus.IMEM_DATA;
            pend_d  = 1'b0;
            // A second INSTR_DONE landing on a pending commit has no word.
            fetch_err_d = fetch_err_q | (done_s & pend_q);
        end else if (cap_q) begin
            stage_d       = bus.IMEM_DATA;
            stage_valid_d = 1'b1;
        end else if (take_stage_s) begin
            instr_d       = stage_q;
            stage_valid_d = 1'b0;
        end else if (done_s) begin
            // BOOT is about to issue the first read, so it can hold a commit too.
            if (!pend_q && (in_flight_s || (state_q == ST_BOOT))) begin
                pend_d = 1'b1;
            end else begin
                fetch_err_d = 1'b1;
            end
        end else begin
            pend_d = pend_q;
        end

        // Fetch acceptance and state sequencing.
        case (state_q)
            ST_BOOT: begin
                fetch_s     = 1'b1;
                state_d     = ST_WAIT;
                fetch_err_d = fetch_err_d | bus.PC_INCR;
            end
            ST_WAIT: begin
                fetch_err_d = fetch_err_d | bus.PC_INCR;
                state_d     = cap_q ? ST_RUN : ST_WAIT;
            end
            ST_RUN: begin
                if (!bus.PC_INCR) begin
                    fetch_s = 1'b0;
                end else if (in_flight_s || (stage_valid_q && !take_stage_s)) begin
                    fetch_err_d = 1'b1;
`ifdef IFU_HALT_ON_STOP_EN
                end else if (stop_commit_s) begin
                    // The STOP word is being committed: the unit halts instead.
                    fetch_s = 1'b0;
`endif
                end else begin
                    fetch_s = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

`ifdef IFU_HALT_ON_STOP_EN
        state_d = stop_commit_s ? ST_HALT : state_d;
`endif

        // Issue the memory read; PC wraps naturally at 2**PC_W.
        if (fetch_s) begin
            imem_en_d   = 1'b1;
            imem_addr_d = pc_q;
            pc_d        = pc_q + PC_ONE;
        end else begin
            imem_en_d   = 1'b0;
        end
    end

    // State and output registers; async reset discards any in-flight read.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= ST_BOOT;
            pc_q          <= {PC_W{1'b0}};
            instr_q       <= {INSTR_W{1'b0}};
            stage_q       <= {INSTR_W{1'b0}};
            stage_valid_q <= 1'b0;
            imem_en_q     <= 1'b0;
            imem_addr_q   <= {PC_W{1'b0}};
            cap_q         <= 1'b0;
            pend_q        <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            stage_q       <= stage_d;
            stage_valid_q <= stage_valid_d;
            imem_en_q     <= imem_en_d;
            imem_addr_q   <= imem_addr_d;
            cap_q         <= cap_d;
            pend_q        <= pend_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign bus.IMEM_EN     = imem_en_q;
    assign bus.IMEM_ADDR   = imem_addr_q;
    assign bus.INSTR       = instr_q;
    assign bus.STAGE_VALID = stage_valid_q;
    assign bus.PC          = pc_q;
    assign bus.FETCH_ERR   = fetch_err_q;

endmodule
